call_panel: RTL
===============

# call_panel

Hall and car call register for the elevator controller: the request-generating end of the `elevator` call interface. Synchronizes and debounces raw hall up/down and in-car floor buttons, and latches each press as a pending call. Drives `move_up_call`, `move_down_call` and `req_floor` into `elevator`. Clears each call when `elevator` reports it served, using its `current_floor`, `direction` and `door_state` outputs.

## Interface
- `NUM_FLOORS`, 4: number of floors; bit i of every vector is floor i.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a level change; range 1..255.
- `FLOOR_W`, `$clog2(NUM_FLOORS)`: floor index width (localparam).
- `clk` in 1: single clock; all state on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `hall_up_btn` in NUM_FLOORS: raw asynchronous hall up buttons, active-high.
- `hall_dn_btn` in NUM_FLOORS: raw asynchronous hall down buttons, active-high.
- `car_btn` in NUM_FLOORS: raw asynchronous in-car floor buttons, active-high.
- `current_floor` in FLOOR_W: from `elevator`.
- `direction` in 2: from `elevator`. Encoding: 00 idle, 01 up, 10 down, 11 treated as idle.
- `door_state` in 1: from `elevator`; 1 means door open.
- `move_up_call` out NUM_FLOORS: pending hall up calls; bit NUM_FLOORS-1 is always 0.
- `move_down_call` out NUM_FLOORS: pending hall down calls; bit 0 is always 0.
- `req_floor` out NUM_FLOORS: pending car calls.
- `any_pending` out 1: OR of all three call vectors.

## Operation
- Reset: all call vectors 0; `any_pending` 0; all synchronizers, debounce counters and debounced levels 0.
- Each of the 3×NUM_FLOORS buttons passes through the same path:
  - 2-flop synchronizer.
  - Debounce counter: increments while the synchronized sample differs from the debounced level, and clears when they agree.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
  - A rise of the debounced level produces a one-cycle `press` pulse.
- Set rule: a `press` sets the matching pending bit. Presses are masked and never latch for:
  - hall up at the top floor;
  - hall down at floor 0.
- Serve condition for floor i: `door_state`=1 and `current_floor`==i.
- Clear rules while floor i is served:
  - `req_floor[i]` clears unconditionally.
  - `move_up_call[i]` clears when `direction` is up or idle/11.
  - `move_down_call[i]` clears when `direction` is down or idle/11.
- Set and clear on the same bit in the same cycle: clear wins and the press is consumed. A button held through service does not re-latch, because latching is edge-based.
- Pending bits hold indefinitely until served. Repeated presses on an already pending bit have no effect.
- Button releases never affect pending state.
- A `current_floor` value ≥ NUM_FLOORS matches no floor.

## Timing
- Press latency: a raw level first sampled high at edge 0 and held stable asserts the pending output after edge `DEBOUNCE_CYCLES`+2. With the default, this is after edge 6.
- Glitch rejection: any pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles is ignored.
- Release path: same latency as the press path; no output effect.
- Clear latency: pending bit low after the first edge at which the serve condition holds. The serve inputs are registered by `elevator` and are used unsynchronized.
- Outputs are registered, with no combinational path from inputs to outputs.
- `any_pending` is combinational from the registered vectors.
- Asynchronous reset mid-debounce discards the partial count. A button held through reset release re-latches after the full press latency.

## Structure
- `elevator_pkg` holds:
  - direction encoding constants `DIR_IDLE`, `DIR_UP`, `DIR_DOWN`;
  - the default `NUM_FLOORS`;
  - the `FLOOR_W` derivation.
- `elevator` imports the same package.
- Sub-module `button_debouncer`: parameter `DEBOUNCE_CYCLES`; contains synchronizer, counter, debounced level and `press` output. `call_panel` generates one instance per button (12 at defaults).
- `call_panel` itself: masking, set/clear logic and output registers.

## Test plan
- Reset, then hold `hall_dn_btn`=4'b1000 for 10 cycles → `move_down_call`=4'b1000 after edge 6 following first sample; `any_pending`=1.
- 3-cycle pulse on `car_btn[1]` → `req_floor` stays 4'b0000. A 5-cycle pulse → `req_floor`=4'b0010.
- Press `hall_up_btn[3]` and `hall_dn_btn[0]` → both vectors stay 0.
- With `move_up_call`=4'b0100 and `move_down_call`=4'b0100 pending, drive `current_floor`=2, `direction`=01, `door_state`=1 → `move_up_call[2]` clears next edge, `move_down_call[2]` stays. Change `direction` to 10 → it clears.
- Hold `car_btn[0]` so its `press` coincides with service at floor 0 with door open → `req_floor[0]` remains 0. Keep the button held after the door closes → no re-latch.
- Assert `rst`=0 mid-debounce with `req_floor`=4'b1001 pending → all outputs 0 immediately. Release reset with the button still held → call re-latches after 6 edges.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller and its call panel:
// direction encoding, default floor count and floor index width.
package elevator_pkg;

    // Direction encoding driven by the elevator; 2'b11 is treated as idle.
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [1:0] DIR_RSVD = 2'b11;

    localparam int DEFAULT_NUM_FLOORS = 4;

    // Floor index width; never narrower than one bit.
    function automatic int floor_w(input int num_floors);
        return (num_floors > 1) ? $clog2(num_floors) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw push button: 2-flop synchronizer, stable-sample debounce counter,
// debounced level and a one-cycle pulse on each accepted press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    // Count value at which the next differing sample is accepted.
    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic [7:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            // NOTE: non-blocking so sync2 takes the old sync1, giving two real flops.
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;    // only a rising debounced level is a press
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/call_panel.sv
// Hall and car call register: debounces every button, latches presses as
// pending calls and clears them when the elevator serves the floor.
module call_panel
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS      = DEFAULT_NUM_FLOORS,
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int FLOOR_W         = floor_w(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] hall_up_btn,
    input  logic [NUM_FLOORS-1:0] hall_dn_btn,
    input  logic [NUM_FLOORS-1:0] car_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic [1:0]            direction,
    input  logic                  door_state,
    output logic [NUM_FLOORS-1:0] move_up_call,
    output logic [NUM_FLOORS-1:0] move_down_call,
    output logic [NUM_FLOORS-1:0] req_floor,
    output logic                  any_pending
);

    // No up call from the top floor, no down call from floor 0.
    localparam logic [NUM_FLOORS-1:0] UP_ALLOW = ~(NUM_FLOORS'(1) << (NUM_FLOORS - 1));
    localparam logic [NUM_FLOORS-1:0] DN_ALLOW = ~NUM_FLOORS'(1);

    logic [NUM_FLOORS-1:0] up_press;
    logic [NUM_FLOORS-1:0] dn_press;
    logic [NUM_FLOORS-1:0] car_press;
    logic [NUM_FLOORS-1:0] serve;
    logic                  up_clr_ok;
    logic                  dn_clr_ok;
    logic [NUM_FLOORS-1:0] up_next;
    logic [NUM_FLOORS-1:0] dn_next;
    logic [NUM_FLOORS-1:0] car_next;

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_floor
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
            .clk(clk), .rst(rst), .raw(hall_up_btn[g]), .press(up_press[g])
        );
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
            .clk(clk), .rst(rst), .raw(hall_dn_btn[g]), .press(dn_press[g])
        );
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_car (
            .clk(clk), .rst(rst), .raw(car_btn[g]), .press(car_press[g])
        );
    end

    // Decode which floor is being served; out-of-range floors match nothing.
    always_comb begin
        // NOTE: assign a default before the loop so no bit is left unassigned (no latch).
        serve = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            serve[i] = door_state && (current_floor == FLOOR_W'(i));
        end
    end

    // Set pending bits on presses; a clear on the same bit wins.
    always_comb begin
        up_clr_ok = (direction == DIR_UP)   || (direction == DIR_IDLE) || (direction == DIR_RSVD);
        dn_clr_ok = (direction == DIR_DOWN) || (direction == DIR_IDLE) || (direction == DIR_RSVD);
        up_next   = (move_up_call   | (up_press & UP_ALLOW)) & ~(serve & {NUM_FLOORS{up_clr_ok}});
        dn_next   = (move_down_call | (dn_press & DN_ALLOW)) & ~(serve & {NUM_FLOORS{dn_clr_ok}});
        car_next  = (req_floor | car_press) & ~serve;
    end

    // Pending call registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            move_up_call   <= '0;
            move_down_call <= '0;
            req_floor      <= '0;
        end else begin
            move_up_call   <= up_next;
            move_down_call <= dn_next;
            req_floor      <= car_next;
        end
    end

    assign any_pending = |{move_up_call, move_down_call, req_floor};

endmodule
